// File: rtl/soc_rtc_host_pkg.sv
// Shared definitions for the RTC host: register offsets, CTRL bit positions
// and the transfer FSM state encoding.
package soc_rtc_host_pkg;

  localparam logic [1:0] REG_SET_TIME = 2'd0;
  localparam logic [1:0] REG_ALARM    = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_TIME     = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_PEND = 1;
  localparam int CTRL_ERR      = 2;
  localparam int CTRL_BUSY     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } rtc_state_e;

endpackage

// File: rtl/soc_rtc_alarm_cmp.sv
// Wrap-aware alarm crossing test between the previous and the new RTC sample.
// With no valid previous sample (first) only an exact match counts.
module soc_rtc_alarm_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] prev_time,
  input  logic [W-1:0] sample,
  input  logic [W-1:0] alarm,
  input  logic         first,
  output logic         hit
);

  // Alarm lies in (prev_time, sample], taking a counter wrap into account
  always_comb begin
    hit = 1'b0;
    if (first) begin
      hit = (sample == alarm);
    end else if (sample >= prev_time) begin
      hit = (alarm > prev_time) && (alarm <= sample);
    end else begin
      hit = (alarm > prev_time) || (alarm <= sample);
    end
  end

endmodule

// File: rtl/soc_rtc_host.sv
// CPU-side host for an external RTC: pushes SET_TIME writes, polls the time
// every POLL_DIV cycles, aborts stalled transfers and raises the alarm irq.
module soc_rtc_host
  import soc_rtc_host_pkg::*;
#(
  parameter int IO_MAP_WIDTH = 32,
  parameter int POLL_DIV     = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cpu_addr,
  input  logic                    cpu_we,
  input  logic [IO_MAP_WIDTH-1:0] cpu_wdata,
  output logic [IO_MAP_WIDTH-1:0] cpu_rdata,
  output logic                    irq,
  output logic [IO_MAP_WIDTH-1:0] rtc_wdata,
  output logic                    rtc_we,
  input  logic [IO_MAP_WIDTH-1:0] rtc_rdata,
  input  logic                    rtc_ready
);

  localparam int PW = $clog2(POLL_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  rtc_state_e              state_r, state_s;
  logic [PW-1:0]           poll_cnt_r, poll_cnt_s;
  logic [TW-1:0]           tmo_cnt_r, tmo_cnt_s;
  logic [IO_MAP_WIDTH-1:0] set_time_r, alarm_r, time_r, ctrl_s;
  logic                    wr_pend_r, en_r, irq_pend_r, err_r, first_r;
  logic                    rtc_we_r, irq_r;
  logic                    wr_ack_s, rd_ack_s, tmo_hit_s, hit_s, busy_s;
  logic                    set_wr_s, alarm_wr_s, ctrl_wr_s;

  assign set_wr_s   = cpu_we && (cpu_addr == REG_SET_TIME);
  assign alarm_wr_s = cpu_we && (cpu_addr == REG_ALARM);
  assign ctrl_wr_s  = cpu_we && (cpu_addr == REG_CTRL);
  assign busy_s     = (state_r != ST_IDLE) || wr_pend_r;

  assign rtc_we    = rtc_we_r;
  assign rtc_wdata = set_time_r;
  assign irq       = irq_r;

  soc_rtc_alarm_cmp #(.W(IO_MAP_WIDTH)) u_alarm_cmp (
    .prev_time (time_r),
    .sample    (rtc_rdata),
    .alarm     (alarm_r),
    .first     (first_r),
    .hit       (hit_s)
  );

  // Next-state logic: pending write beats poll, ready beats timeout
  always_comb begin
    state_s    = state_r;
    poll_cnt_s = poll_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    wr_ack_s   = 1'b0;
    rd_ack_s   = 1'b0;
    tmo_hit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_s = '0;
        if (wr_pend_r) begin
          state_s    = ST_WR;
          poll_cnt_s = '0;
        end else if (poll_cnt_r == POLL_LAST) begin
          state_s    = ST_RD;
          poll_cnt_s = '0;
        end else begin
          poll_cnt_s = poll_cnt_r + PW'(1);
        end
      end
      ST_WR, ST_RD: begin
        if (rtc_ready) begin
          wr_ack_s   = (state_r == ST_WR);
          rd_ack_s   = (state_r == ST_RD);
          state_s    = ST_IDLE;
          poll_cnt_s = '0;
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_hit_s  = 1'b1;
          state_s    = ST_IDLE;
          poll_cnt_s = '0;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        poll_cnt_s = '0;
        tmo_cnt_s  = '0;
      end
    endcase
  end

  // Register state; every hardware set event wins over a same-cycle CPU clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      poll_cnt_r <= '0;
      tmo_cnt_r  <= '0;
      set_time_r <= '0;
      alarm_r    <= '0;
      time_r     <= '0;
      wr_pend_r  <= 1'b0;
      en_r       <= 1'b0;
      irq_pend_r <= 1'b0;
      err_r      <= 1'b0;
      first_r    <= 1'b1;
      rtc_we_r   <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      poll_cnt_r <= poll_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      rtc_we_r   <= (state_s == ST_WR);
      irq_r      <= irq_pend_r & en_r;
      if (set_wr_s) begin
        set_time_r <= cpu_wdata;
        wr_pend_r  <= 1'b1;
      end else if (wr_ack_s) begin
        wr_pend_r  <= 1'b0;
      end else begin
        wr_pend_r  <= wr_pend_r;
      end
      if (alarm_wr_s) begin
        alarm_r <= cpu_wdata;
      end else begin
        alarm_r <= alarm_r;
      end
      if (ctrl_wr_s) begin
        en_r <= cpu_wdata[CTRL_EN];
      end else begin
        en_r <= en_r;
      end
      if (rd_ack_s && en_r && hit_s) begin
        irq_pend_r <= 1'b1;
      end else if (ctrl_wr_s && cpu_wdata[CTRL_IRQ_PEND]) begin
        irq_pend_r <= 1'b0;
      end else begin
        irq_pend_r <= irq_pend_r;
      end
      if (tmo_hit_s) begin
        err_r <= 1'b1;
      end else if (ctrl_wr_s && cpu_wdata[CTRL_ERR]) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
      if (rd_ack_s) begin
        time_r <= rtc_rdata;
      end else begin
        time_r <= time_r;
      end
      // A new time base invalidates the previous sample for crossing tests
      if (wr_ack_s) begin
        first_r <= 1'b1;
      end else if (rd_ack_s) begin
        first_r <= 1'b0;
      end else begin
        first_r <= first_r;
      end
    end
  end

  // CPU read mux
  always_comb begin
    ctrl_s                = '0;
    ctrl_s[CTRL_EN]       = en_r;
    ctrl_s[CTRL_IRQ_PEND] = irq_pend_r;
    ctrl_s[CTRL_ERR]      = err_r;
    ctrl_s[CTRL_BUSY]     = busy_s;
    case (cpu_addr)
      REG_SET_TIME: cpu_rdata = set_time_r;
      REG_ALARM:    cpu_rdata = alarm_r;
      REG_CTRL:     cpu_rdata = ctrl_s;
      REG_TIME:     cpu_rdata = time_r;
      default:      cpu_rdata = '0;
    endcase
  end

endmodule

// File: doc/soc_rtc_host.md
SOC_RTC_HOST -- requirements
Module: soc_rtc_host

Interface
REQ-001 Parameter IO_MAP_WIDTH, default 32: width of all data paths.
REQ-002 Parameter POLL_DIV, default 16: clk cycles from one completed read to the next read request.
REQ-003 Parameter TIMEOUT, default 64: maximum clk cycles to wait for rtc_ready before a transfer is aborted.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_addr  in  2  register select: 0 SET_TIME, 1 ALARM, 2 CTRL, 3 TIME.
REQ-007 cpu_we  in  1  one-cycle register write strobe.
REQ-008 cpu_wdata  in  IO_MAP_WIDTH  register write data.
REQ-009 cpu_rdata  out  IO_MAP_WIDTH  combinational read of the register selected by cpu_addr.
REQ-010 irq  out  1  alarm interrupt, level, registered.
REQ-011 rtc_wdata  out  IO_MAP_WIDTH  time value driven to the RTC.
REQ-012 rtc_we  out  1  RTC write request, held until acknowledged.
REQ-013 rtc_rdata  in  IO_MAP_WIDTH  current RTC time.
REQ-014 rtc_ready  in  1  RTC acknowledge: write accepted, or rtc_rdata valid.

Function
REQ-015 Register map:
- SET_TIME write: latches cpu_wdata and sets wr_pend.
- ALARM: read/write.
- CTRL bit0 en (R/W); bit1 irq_pend (write 1 clears); bit2 err (write 1 clears); bit3 busy (read-only).
- TIME: last sampled RTC time, read-only.
REQ-016 FSM states are IDLE, WR and RD.
REQ-017 IDLE:
- wr_pend=1 goes to WR next cycle.
- Otherwise, when poll_cnt reaches POLL_DIV-1, go to RD.
- wr_pend has priority over a poll.
REQ-018 WR:
- rtc_we=1 and rtc_wdata holds the latched value.
- On the first cycle with rtc_ready=1: clear wr_pend, rtc_we=0 next cycle, go to IDLE.
- poll_cnt resets to 0 on exit.
REQ-019 RD:
- On the first cycle with rtc_ready=1, sample rtc_rdata into TIME; go to IDLE with poll_cnt=0.
- TIME updates exactly 1 cycle after the ready edge.
REQ-020 Timeout:
- A tmo_cnt increments in WR/RD and resets on entry.
- When it reaches TIMEOUT-1 without rtc_ready: set err, go to IDLE.
- WR abort: wr_pend stays set, so the write retries.
- RD abort: TIME is unchanged.
REQ-021 A SET_TIME write during WR:
- Overwrites the latched value only if it occurs before the ack cycle.
- A write in the ack cycle sets wr_pend again and is sent by a new WR.
REQ-022 busy=1 in WR or RD, or when wr_pend=1.
REQ-023 Alarm detection on each new sample S with previous sample P, with en=1 (unsigned comparison):
- If S>=P: set irq_pend when P<ALARM<=S.
- If S<P (counter wrap): set irq_pend when ALARM>P or ALARM<=S.
REQ-024 The first sample after reset or after a SET_TIME ack sets irq_pend only if S==ALARM.
REQ-025 irq = irq_pend & en, registered.
REQ-026 If a set event and a CPU clear of irq_pend (or err) fall in the same cycle, set wins.
REQ-027 Changing ALARM or en does not re-evaluate past samples.

Reset
REQ-028 rst asserted resets immediately and asynchronously; outputs are valid within the same cycle, including mid-transfer.
REQ-029 Reset values:
- state=IDLE, rtc_we=0, rtc_wdata=0, irq=0.
- TIME=0, ALARM=0, CTRL=0, wr_pend=0, poll_cnt=0, tmo_cnt=0.
- first-sample flag set.

Structure
REQ-030 A shared package holds the register offset constants, CTRL bit positions and the FSM state encoding.
REQ-031 The wrap-aware crossing comparator is a sub-module, soc_rtc_alarm_cmp (inputs P, S, ALARM, first; output hit).

Verification
REQ-032 Scenario: SET_TIME=0x100, RTC raises rtc_ready 3 cycles after rtc_we.
- rtc_we is high for exactly 4 cycles with rtc_wdata=0x100.
- busy then drops.
REQ-033 Scenario: en=1, ALARM=0x105, RTC time steps 0x103->0x104->0x106 across polls.
- irq rises 1-2 cycles after the 0x106 sample.
- TIME=0x106.
REQ-034 Scenario: wrap with P=0xFFFFFFFE, S=0x00000001, ALARM=0x00000000.
- irq_pend is set.
- With ALARM=0x00000005 it stays 0.
REQ-035 Scenario: rtc_ready held low during RD.
- After 64 cycles: err=1, state IDLE, TIME unchanged.
- The next poll proceeds after POLL_DIV cycles.
REQ-036 Scenario: CTRL write with bit1=1 in the same cycle as an alarm hit.
- irq_pend stays 1.
- A later clear-only write drops irq one cycle after.
REQ-037 Scenario: rst asserted while rtc_we=1 in WR.
- rtc_we=0 and irq=0 with no clock edge.
- wr_pend=0 after release.
